// File: rtl/reg_operand_fetch_pkg.sv
// Register-file port types plus the operand-fetch stage's own instruction/result types.
package PkgRegisterFile;
    localparam int MSB_POS__REG_FILE_SEL  = 3;
    localparam int MSB_POS__REG_FILE_DATA = 31;

    typedef struct packed {
        logic [MSB_POS__REG_FILE_SEL:0]  read_sel_ra;
        logic [MSB_POS__REG_FILE_SEL:0]  read_sel_rb;
        logic [MSB_POS__REG_FILE_SEL:0]  read_sel_rc;
        logic [MSB_POS__REG_FILE_SEL:0]  write_sel;
        logic [MSB_POS__REG_FILE_DATA:0] write_data;
        logic                            write_en;
    } PortIn_RegFile;

    typedef struct packed {
        logic [MSB_POS__REG_FILE_DATA:0] read_data_ra;
        logic [MSB_POS__REG_FILE_DATA:0] read_data_rb;
        logic [MSB_POS__REG_FILE_DATA:0] read_data_rc;
    } PortOut_RegFile;
endpackage

package PkgOperandFetch;
    import PkgRegisterFile::*;

    localparam int NUM_SRC = 3;
    localparam logic [MSB_POS__REG_FILE_SEL:0] REG_ZERO = '0;

    // Source index 0/1/2 = ra/rb/rc throughout.
    typedef struct packed {
        logic [NUM_SRC-1:0][MSB_POS__REG_FILE_SEL:0] sel;
        logic [NUM_SRC-1:0]                          use_src;
        logic [MSB_POS__REG_FILE_SEL:0]              dest_sel;
        logic                                        dest_en;
    } PortIn_OperandFetch;

    typedef struct packed {
        logic [NUM_SRC-1:0][MSB_POS__REG_FILE_DATA:0] data;
        logic [MSB_POS__REG_FILE_SEL:0]               dest_sel;
        logic                                         dest_en;
    } PortOut_OperandFetch;
endpackage

// File: rtl/reg_operand_fetch_scoreboard.sv
// Per-register busy bits for in-flight destinations, with hazard queries that
// already see this cycle's writeback clear.
module reg_scoreboard #(
    parameter int SEL_WIDTH = 4,
    parameter int NUM_Q     = 4
) (
    input  logic                              clk,
    input  logic                              rst_n,
    input  logic                              set_en,
    input  logic [SEL_WIDTH-1:0]              set_sel,
    input  logic                              clr_en,
    input  logic [SEL_WIDTH-1:0]              clr_sel,
    input  logic                              flush_clr_en,
    input  logic [SEL_WIDTH-1:0]              flush_clr_sel,
    input  logic [NUM_Q-1:0][SEL_WIDTH-1:0]   query_sel,
    output logic [NUM_Q-1:0]                  query_busy,
    output logic [2**SEL_WIDTH-1:0]           busy_vec
);
    localparam int NUM_REGS = 2**SEL_WIDTH;

    logic [NUM_REGS-1:0] busy, busy_nxt;

    always_comb begin
        busy_nxt = busy;
        if (clr_en)       busy_nxt[clr_sel]       = 1'b0;
        if (flush_clr_en) busy_nxt[flush_clr_sel] = 1'b0;
        // Set is applied last so a re-issued destination stays busy.
        if (set_en && set_sel != '0) busy_nxt[set_sel] = 1'b1;
        busy_nxt[0] = 1'b0;
    end

    always_ff @(posedge clk) begin
        if (!rst_n) busy <= '0;
        else        busy <= busy_nxt;
    end

    for (genvar q = 0; q < NUM_Q; q++) begin : g_query
        assign query_busy[q] = busy[query_sel[q]] && !(clr_en && clr_sel == query_sel[q]);
    end

    assign busy_vec = busy;
endmodule

// File: rtl/reg_operand_fetch.sv
// Operand fetch with writeback bypass, busy-scoreboard stall and a single
// valid/ready output register.
module reg_operand_fetch
    import PkgRegisterFile::*;
    import PkgOperandFetch::*;
#(
    parameter int SEL_WIDTH  = 4,
    parameter int DATA_WIDTH = 32
) (
    input  logic                       clk,
    input  logic                       rst_n,
    input  logic                       in_valid,
    output logic                       in_ready,
    input  logic [SEL_WIDTH-1:0]       in_sel_ra,
    input  logic [SEL_WIDTH-1:0]       in_sel_rb,
    input  logic [SEL_WIDTH-1:0]       in_sel_rc,
    input  logic                       in_use_ra,
    input  logic                       in_use_rb,
    input  logic                       in_use_rc,
    input  logic [SEL_WIDTH-1:0]       in_dest_sel,
    input  logic                       in_dest_en,
    output logic                       out_valid,
    input  logic                       out_ready,
    output logic [DATA_WIDTH-1:0]      out_data_ra,
    output logic [DATA_WIDTH-1:0]      out_data_rb,
    output logic [DATA_WIDTH-1:0]      out_data_rc,
    output logic [SEL_WIDTH-1:0]       out_dest_sel,
    output logic                       out_dest_en,
    input  logic                       wb_valid,
    input  logic [SEL_WIDTH-1:0]       wb_sel,
    input  logic [DATA_WIDTH-1:0]      wb_data,
    input  logic                       flush,
    output PortIn_RegFile              rf_in,
    input  PortOut_RegFile             rf_out,
    output logic [2**SEL_WIDTH-1:0]    busy_vec
);
    PortIn_OperandFetch                  instr;
    PortOut_OperandFetch                 ofs_q;
    logic [NUM_SRC-1:0][DATA_WIDTH-1:0]  rf_data, opnd;
    logic [NUM_SRC:0][SEL_WIDTH-1:0]     q_sel;
    logic [NUM_SRC:0]                    q_busy;
    logic                                hazard, capture, flush_clr;

    assign instr.sel      = {in_sel_rc, in_sel_rb, in_sel_ra};
    assign instr.use_src  = {in_use_rc, in_use_rb, in_use_ra};
    assign instr.dest_sel = in_dest_sel;
    assign instr.dest_en  = in_dest_en;

    always_comb begin
        rf_in.read_sel_ra = in_sel_ra;
        rf_in.read_sel_rb = in_sel_rb;
        rf_in.read_sel_rc = in_sel_rc;
        rf_in.write_sel   = wb_sel;
        rf_in.write_data  = wb_data;
        rf_in.write_en    = rst_n && wb_valid && (wb_sel != REG_ZERO);
    end

    assign rf_data = {rf_out.read_data_rc, rf_out.read_data_rb, rf_out.read_data_ra};

    for (genvar i = 0; i < NUM_SRC; i++) begin : g_src
        assign opnd[i] = (instr.sel[i] == REG_ZERO)                ? '0      :
                         (wb_valid && wb_sel == instr.sel[i])      ? wb_data :
                                                                     rf_data[i];
    end

    // Queries 0..NUM_SRC-1 are sources, the last one is the destination (WAW).
    assign q_sel     = {instr.dest_sel, instr.sel};
    assign hazard    = |(instr.use_src & q_busy[NUM_SRC-1:0]) || (instr.dest_en && q_busy[NUM_SRC]);
    assign in_ready  = rst_n && !hazard && (!out_valid || out_ready) && !flush;
    assign capture   = in_valid && in_ready;
    assign flush_clr = flush && out_valid && ofs_q.dest_en && (ofs_q.dest_sel != REG_ZERO);

    reg_scoreboard #(
        .SEL_WIDTH (SEL_WIDTH),
        .NUM_Q     (NUM_SRC + 1)
    ) u_scoreboard (
        .clk           (clk),
        .rst_n         (rst_n),
        .set_en        (capture && in_dest_en),
        .set_sel       (in_dest_sel),
        .clr_en        (wb_valid),
        .clr_sel       (wb_sel),
        .flush_clr_en  (flush_clr),
        .flush_clr_sel (ofs_q.dest_sel),
        .query_sel     (q_sel),
        .query_busy    (q_busy),
        .busy_vec      (busy_vec)
    );

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            out_valid <= 1'b0;
            ofs_q     <= '0;
        end else if (flush) begin
            out_valid <= 1'b0;
        end else if (capture) begin
            out_valid      <= 1'b1;
            ofs_q.data     <= opnd;
            ofs_q.dest_sel <= instr.dest_sel;
            ofs_q.dest_en  <= instr.dest_en;
        end else if (out_ready) begin
            out_valid <= 1'b0;
        end
    end

    assign out_data_ra  = ofs_q.data[0];
    assign out_data_rb  = ofs_q.data[1];
    assign out_data_rc  = ofs_q.data[2];
    assign out_dest_sel = ofs_q.dest_sel;
    assign out_dest_en  = ofs_q.dest_en;
endmodule

// File: tb/tb_reg_operand_fetch.sv
// Randomized scoreboard bench for reg_operand_fetch with a register-level reference model.
module tb_reg_operand_fetch;
    import PkgRegisterFile::*;
    import PkgOperandFetch::*;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        in_valid, in_ready;
    logic [3:0]  in_sel_ra, in_sel_rb, in_sel_rc, in_dest_sel;
    logic        in_use_ra, in_use_rb, in_use_rc, in_dest_en;
    logic        out_valid, out_ready;
    logic [31:0] out_data_ra, out_data_rb, out_data_rc;
    logic [3:0]  out_dest_sel;
    logic        out_dest_en;
    logic        wb_valid;
    logic [3:0]  wb_sel;
    logic [31:0] wb_data;
    logic        flush;
    PortIn_RegFile  rf_in;
    PortOut_RegFile rf_out;
    logic [15:0] busy_vec;

    always #5 clk = ~clk;

    reg_operand_fetch dut (
        .clk(clk), .rst_n(rst_n),
        .in_valid(in_valid), .in_ready(in_ready),
        .in_sel_ra(in_sel_ra), .in_sel_rb(in_sel_rb), .in_sel_rc(in_sel_rc),
        .in_use_ra(in_use_ra), .in_use_rb(in_use_rb), .in_use_rc(in_use_rc),
        .in_dest_sel(in_dest_sel), .in_dest_en(in_dest_en),
        .out_valid(out_valid), .out_ready(out_ready),
        .out_data_ra(out_data_ra), .out_data_rb(out_data_rb), .out_data_rc(out_data_rc),
        .out_dest_sel(out_dest_sel), .out_dest_en(out_dest_en),
        .wb_valid(wb_valid), .wb_sel(wb_sel), .wb_data(wb_data),
        .flush(flush), .rf_in(rf_in), .rf_out(rf_out), .busy_vec(busy_vec)
    );

    // Register file environment: written through rf_in, read combinationally.
    logic [31:0] rf_arr [16];
    initial for (int i = 0; i < 16; i++) rf_arr[i] = '0;
    always @(posedge clk) if (rf_in.write_en) rf_arr[rf_in.write_sel] <= rf_in.write_data;
    always_comb begin
        rf_out.read_data_ra = rf_arr[rf_in.read_sel_ra];
        rf_out.read_data_rb = rf_arr[rf_in.read_sel_rb];
        rf_out.read_data_rc = rf_arr[rf_in.read_sel_rc];
    end

    // Reference model: architectural register values, busy set, held instruction.
    logic [31:0] reg_m [16];
    logic [15:0] busy_m;
    bit          held_m;
    logic [3:0]  held_dest;
    bit          held_en;
    PortOut_OperandFetch exp_q [$];
    int n_cmp = 0, n_fail = 0;

    function automatic void check(string nm, logic [127:0] act, logic [127:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h (t=%0t)", nm, act, exp, $time);
        end
    endfunction

    // Monitor: compares each delivered instruction with the oldest expected one.
    always @(negedge clk) begin
        if (rst_n === 1'b1 && out_valid === 1'b1) begin
            if (flush) begin
                if (exp_q.size() > 0) void'(exp_q.pop_front());
            end else if (out_ready) begin
                if (exp_q.size() == 0) check("deliver_unexpected", 1, 0);
                else check("deliver", {out_data_rc, out_data_rb, out_data_ra, out_dest_sel, out_dest_en},
                           exp_q.pop_front());
            end
        end
    end

    task automatic idle();
        in_valid = 0; in_sel_ra = 0; in_sel_rb = 0; in_sel_rc = 0;
        in_use_ra = 0; in_use_rb = 0; in_use_rc = 0; in_dest_sel = 0; in_dest_en = 0;
        wb_valid = 0; wb_sel = 0; wb_data = 0; flush = 0; out_ready = 1;
    endtask

    // One cycle: predict from the current inputs, compare at negedge, advance the model.
    task automatic step();
        logic [3:0] s [3];
        bit u [3];
        bit haz, rdy, cap;
        PortOut_OperandFetch e;
        @(negedge clk);
        s[0] = in_sel_ra; s[1] = in_sel_rb; s[2] = in_sel_rc;
        u[0] = in_use_ra; u[1] = in_use_rb; u[2] = in_use_rc;
        haz = 0;
        for (int i = 0; i < 3; i++)
            if (u[i] && busy_m[s[i]] && !(wb_valid && wb_sel == s[i])) haz = 1;
        if (in_dest_en && busy_m[in_dest_sel] && !(wb_valid && wb_sel == in_dest_sel)) haz = 1;
        rdy = rst_n && !haz && (!held_m || out_ready) && !flush;
        check("in_ready", in_ready, rdy);
        check("busy_vec", busy_vec, busy_m);
        check("out_valid", out_valid, held_m);
        check("rf_write_en", rf_in.write_en, rst_n && wb_valid && wb_sel != 0);
        cap = in_valid && rdy;
        if (cap) begin
            for (int i = 0; i < 3; i++)
                e.data[i] = (s[i] == 0) ? 32'h0 : (wb_valid && wb_sel == s[i]) ? wb_data : reg_m[s[i]];
            e.dest_sel = in_dest_sel;
            e.dest_en  = in_dest_en;
            exp_q.push_back(e);
        end
        if (!rst_n) begin
            busy_m = '0; held_m = 0; exp_q.delete();
        end else begin
            if (wb_valid) busy_m[wb_sel] = 1'b0;
            if (flush && held_m && held_en && held_dest != 0) busy_m[held_dest] = 1'b0;
            if (cap && in_dest_en && in_dest_sel != 0) busy_m[in_dest_sel] = 1'b1;
            if (flush) held_m = 0;
            else if (cap) begin held_m = 1; held_dest = in_dest_sel; held_en = in_dest_en; end
            else if (out_ready) held_m = 0;
            if (wb_valid && wb_sel != 0) reg_m[wb_sel] = wb_data;
        end
        @(posedge clk); #1;
    endtask

    task automatic randomize_inputs();
        int k;
        in_valid  = ($urandom_range(0, 9) < 7);
        in_sel_ra = 4'($urandom_range(0, 7));
        in_sel_rb = 4'($urandom_range(0, 7));
        in_sel_rc = 4'($urandom_range(0, 7));
        in_use_ra = 1'($urandom); in_use_rb = 1'($urandom); in_use_rc = 1'($urandom);
        in_dest_sel = 4'($urandom_range(0, 7));
        in_dest_en  = 1'($urandom);
        wb_valid = ($urandom_range(0, 9) < 4);
        wb_sel   = 4'($urandom_range(0, 15));
        if (busy_m != 0 && $urandom_range(0, 1) == 1) begin
            k = $urandom_range(0, 15);
            for (int j = 0; j < 16; j++)
                if (busy_m[(k + j) % 16]) begin wb_sel = 4'((k + j) % 16); break; end
        end
        wb_data   = $urandom;
        flush     = ($urandom_range(0, 15) == 0);
        out_ready = ($urandom_range(0, 3) != 0);
    endtask

    initial begin
        for (int i = 0; i < 16; i++) reg_m[i] = '0;
        busy_m = '0; held_m = 0; held_dest = 0; held_en = 0;
        idle();
        rst_n = 0;
        #1;
        step(); step();
        rst_n = 1;
        check("rst_out_data", {out_data_rc, out_data_rb, out_data_ra}, 0);
        check("rst_out_dest", {out_dest_sel, out_dest_en}, 0);

        // Basic read through the register file.
        wb_valid = 1; wb_sel = 3; wb_data = 32'h0000_1234; step();
        idle(); in_valid = 1; in_sel_ra = 3; in_use_ra = 1; step();
        check("basic_ra", out_data_ra, 32'h0000_1234);
        idle(); step();

        // RAW stall released by a same-cycle writeback via the bypass.
        in_valid = 1; in_dest_sel = 5; in_dest_en = 1; step();
        idle(); in_valid = 1; in_sel_rb = 5; in_use_rb = 1; in_dest_sel = 5; in_dest_en = 1;
        step(); step();
        wb_valid = 1; wb_sel = 5; wb_data = 32'hDEAD_BEEF; step();
        check("raw_rb", out_data_rb, 32'hDEAD_BEEF);
        check("raw_busy5", busy_vec[5], 1'b1);
        idle(); wb_valid = 1; wb_sel = 5; wb_data = 32'h5555_0005; step();

        // Backpressure for three cycles, then release.
        idle(); in_valid = 1; in_sel_ra = 3; in_sel_rc = 5; in_dest_sel = 2; in_dest_en = 1; step();
        in_sel_ra = 5; in_dest_sel = 4; out_ready = 0;
        step(); step(); step();
        out_ready = 1; step();
        idle(); step();
        wb_valid = 1; wb_sel = 2; step();
        wb_sel = 4; step();

        // Flush of a held instruction releases its destination.
        idle(); in_valid = 1; in_dest_sel = 7; in_dest_en = 1; step();
        idle(); flush = 1; out_ready = 0; step();
        idle(); check("flush_busy7", busy_vec[7], 1'b0);
        check("flush_valid", out_valid, 1'b0);
        step();

        // r0: writes suppressed, reads zero, never busy.
        wb_valid = 1; wb_sel = 0; wb_data = 32'hFFFF_FFFF; step();
        idle(); in_valid = 1; in_sel_ra = 0; in_use_ra = 1; in_dest_sel = 0; in_dest_en = 1; step();
        check("r0_ra", out_data_ra, 0);
        idle(); step();

        // Randomized traffic with one reset in the middle.
        for (int n = 0; n < 3000; n++) begin
            randomize_inputs();
            rst_n = !(n == 1500 || n == 1501);
            step();
        end

        idle(); rst_n = 1;
        step(); step(); step();
        check("drain", exp_q.size(), 0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
        $finish;
    end
endmodule
